// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit constants and the {pc, inst} entry type passed to decode.
package instruction_fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int DEF_IMEM_AW = 10;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} queue between the memory response and decode.
module fetch_fifo
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t [1:0] mem;
  logic rd_ptr, wr_ptr;
  logic do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: issues one word per cycle to the 1-cycle-latency imem and queues
// {pc, inst} for decode; execute redirects flush everything in flight.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IMEM_AW  = DEF_IMEM_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_ce,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_d,
  input  logic [31:0]        imem_q,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc
);
  logic [31:0]        pc, req_pc;
  logic               req_valid;
  logic [IMEM_AW-1:0] addr_q;
  logic [1:0]         fifo_count;
  logic [2:0]         occ;
  logic               deq, issue;
  fetch_entry_t       head, din;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign deq = inst_valid && inst_ready;
  // Slots already committed: queued entries plus the in-flight word, less one leaving now.
  assign occ = 3'(fifo_count) + 3'(req_valid) - 3'(deq);
  // reset_n gates issue so the memory port is idle while reset is held.
  assign issue = reset_n && fetch_en && !redirect_valid && (occ < 3'(FIFO_DEPTH));

  // Re-presenting req_pc keeps the memory's registered address, and hence q, steady.
  assign imem_ce   = issue || req_valid;
  assign imem_addr = issue     ? pc[IMEM_AW+1:2] :
                     req_valid ? req_pc[IMEM_AW+1:2] : addr_q;
  assign imem_we   = 1'b0;
  assign imem_d    = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (imem_ce) addr_q <= imem_addr;
      if (redirect_valid) begin
        pc        <= {redirect_pc[31:2], 2'b00};
        req_valid <= 1'b0;
      end else if (issue) begin
        req_pc    <= pc;
        pc        <= pc + 32'd4;
        req_valid <= 1'b1;
      end else begin
        req_valid <= 1'b0;
      end
    end
  end

  assign din = '{pc: req_pc, inst: imem_q};

  fetch_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid && !redirect_valid),
    .pop     (deq),
    .flush   (redirect_valid),
    .din     (din),
    .count   (fifo_count),
    .head    (head)
  );

  assign inst_valid = (fifo_count != 2'd0);
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;
endmodule
